// File: rtl/bullet_pool_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bullet_pool_ctrl
//  Purpose  : Fixed pool of player-bullet slots. Allocates a slot on fire,
//             steps every live bullet upward once per game tick, retires
//             bullets leaving the top of the screen or reported as hit, and
//             renders the pool onto the pixel stream (registered en/colour).
//  Ports    : clk, rst (async, active-high)
//             tick               one-cycle game-step pulse
//             fire               player fire request (level)
//             p_x, p_y           player position (spawn origin)
//             hit_valid/hit_slot collision report
//             x, y               current pixel coordinate
//             fire_ack/fire_slot spawn pulse and last allocated slot
//             active             per-slot live flags
//             bx_flat, by_flat   slot positions, slot i at [10i+9:10i]
//             bullet_en/rgb      registered pixel enable / colour
//  Options  : BULLET_AUTOFIRE_EN - when defined, holding fire spawns every
//             COOLDOWN ticks; otherwise each rising edge of fire queues one
//             shot.
//  Revision : 1.0 - initial release
// ============================================================================
module bullet_pool_ctrl #(
    parameter int SLOTS    = 4,
    parameter int COOLDOWN = 20,
    parameter int SPEED    = 2,
    parameter int OFF_X    = 23,
    parameter int B_W      = 10,
    parameter int B_H      = 40,
    localparam int SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  fire,
    input  logic [9:0]            p_x,
    input  logic [9:0]            p_y,
    input  logic                  hit_valid,
    input  logic [SW-1:0]         hit_slot,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    output logic                  fire_ack,
    output logic [SW-1:0]         fire_slot,
    output logic [SLOTS-1:0]      active,
    output logic [SLOTS*10-1:0]   bx_flat,
    output logic [SLOTS*10-1:0]   by_flat,
    output logic                  bullet_en,
    output logic [11:0]           bullet_rgb
);

    localparam int CW = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        SPAWN = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   idx;
    logic            tick_pend;
    logic [CW-1:0]   cooldown;
    logic [9:0]      bx [SLOTS];
    logic [9:0]      by [SLOTS];

    logic            free_found;
    logic [SW-1:0]   free_idx;
    logic [CW-1:0]   cd_next;
    logic            fire_cond;
    logic            do_spawn;
    logic            pix_hit;

`ifdef BULLET_AUTOFIRE_EN
    assign fire_cond = fire;
`else
    logic            fire_q;
    logic            fire_pend;
    assign fire_cond = fire_pend;
`endif

    // Lowest-index free slot: scan downward so the lowest index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    // The spawn gate looks at the already-decremented cooldown, so spawns are
    // spaced exactly COOLDOWN ticks apart.
    assign cd_next  = (cooldown == '0) ? '0 : cooldown - 1'b1;
    assign do_spawn = (state == SPAWN) && fire_cond && (cd_next == '0) && free_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            tick_pend <= 1'b0;
            cooldown  <= '0;
            active    <= '0;
            fire_ack  <= 1'b0;
            fire_slot <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                bx[i] <= '0;
                by[i] <= '0;
            end
`ifndef BULLET_AUTOFIRE_EN
            fire_q    <= 1'b0;
            fire_pend <= 1'b0;
`endif
        end else begin
            fire_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (tick || tick_pend) begin
                        state     <= MOVE;
                        tick_pend <= 1'b0;
                        idx       <= '0;
                    end
                end
                MOVE: begin
                    if (tick) tick_pend <= 1'b1;
                    if (active[idx]) begin
                        if (by[idx] < 10'(SPEED)) begin
                            active[idx] <= 1'b0;
                        end else if (!(hit_valid && hit_slot == idx)) begin
                            // A coincident hit leaves the position untouched.
                            by[idx] <= by[idx] - 10'(SPEED);
                        end
                    end
                    if (idx == SW'(SLOTS - 1)) begin
                        state <= SPAWN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SPAWN: begin
                    if (tick) tick_pend <= 1'b1;
                    cooldown <= cd_next;
                    state    <= IDLE;
`ifndef BULLET_AUTOFIRE_EN
                    // Full pool: the pending request is dropped, not queued.
                    if (!free_found) fire_pend <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase

            // Hits clear in any state; a spawn into the same slot wins.
            if (hit_valid && !(do_spawn && free_idx == hit_slot))
                active[hit_slot] <= 1'b0;

            if (do_spawn) begin
                active[free_idx] <= 1'b1;
                bx[free_idx]     <= p_x + 10'(OFF_X);
                by[free_idx]     <= p_y;
                cooldown         <= CW'(COOLDOWN);
                fire_ack         <= 1'b1;
                fire_slot        <= free_idx;
`ifndef BULLET_AUTOFIRE_EN
                fire_pend        <= 1'b0;
`endif
            end

`ifndef BULLET_AUTOFIRE_EN
            fire_q <= fire;
            if (fire && !fire_q) fire_pend <= 1'b1;
`endif
        end
    end

    generate
        for (genvar g = 0; g < SLOTS; g++) begin : g_flat
            assign bx_flat[g*10 +: 10] = bx[g];
            assign by_flat[g*10 +: 10] = by[g];
        end
    endgenerate

    // Pixel test in 11 bits so a bullet near the right/bottom edge never wraps.
    always_comb begin
        pix_hit = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (active[i] &&
                ({1'b0, x} >= {1'b0, bx[i]}) && ({1'b0, x} < {1'b0, bx[i]} + 11'(B_W)) &&
                ({1'b0, y} >= {1'b0, by[i]}) && ({1'b0, y} < {1'b0, by[i]} + 11'(B_H)))
                pix_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bullet_en  <= 1'b0;
            bullet_rgb <= '0;
        end else begin
            bullet_en  <= pix_hit;
            bullet_rgb <= pix_hit ? 12'hFFF : 12'h000;
        end
    end

endmodule
`default_nettype wire
